// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel custom-instruction controller.
// Optional build macro: SOBEL_ZERO_SKIP_EN (sequencer visits only non-zero taps).
package sobel_pkg;

    // Instruction op field, valueB[1:0]
    localparam logic [1:0] OP_LOAD    = 2'd0;
    localparam logic [1:0] OP_COMPUTE = 2'd1;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Gradient accumulator width: worst case |sum| = 4*255 = 1020
    localparam int ACC_W = 12;

    // Number of MAC steps for the full and the zero-skipping sequences
    localparam int STEPS_FULL = 18;
    localparam int STEPS_SKIP = 12;

    // Kernel coefficients, 3-bit two's complement, indexed by tap = 3*row + col.
    // Listed from tap 8 down to tap 0.
    //   GX: -1 0 1 / -2 0 2 / -1 0 1
    localparam logic [8:0][2:0] GX_COEF = {
        3'b001, 3'b000, 3'b111,
        3'b010, 3'b000, 3'b110,
        3'b001, 3'b000, 3'b111
    };
    //   GY: -1 -2 -1 / 0 0 0 / 1 2 1
    localparam logic [8:0][2:0] GY_COEF = {
        3'b001, 3'b010, 3'b001,
        3'b000, 3'b000, 3'b000,
        3'b111, 3'b110, 3'b111
    };

    // Tap visited at each step of the zero-skipping sequence (step 11 down to 0).
    // Steps 0..5 belong to Gx (taps 0,2,3,5,6,8), steps 6..11 to Gy (taps 0,1,2,6,7,8).
    localparam logic [11:0][3:0] SKIP_TAP = {
        4'd8, 4'd7, 4'd6, 4'd2, 4'd1, 4'd0,
        4'd8, 4'd6, 4'd5, 4'd3, 4'd2, 4'd0
    };

endpackage

// File: rtl/sobel_tap_mult.sv
// Shared coefficient multiplier: unsigned pixel times a factor in {-2,-1,0,1,2}.
// Built from shift and negate only; the result is a 12-bit signed product.
module sobel_tap_mult
    import sobel_pkg::*;
(
    input  logic [7:0]              pixel_i,
    input  logic [2:0]              factor_i,
    output logic signed [ACC_W-1:0] product_o
);

    logic [ACC_W-1:0] mag;

    // Magnitude by shift, then negate for negative factors
    always_comb begin
        mag = '0;
        case (factor_i)
            3'b001, 3'b111: mag = {4'd0, pixel_i};
            3'b010, 3'b110: mag = {3'd0, pixel_i, 1'b0};
            default:        mag = '0;
        endcase
        product_o = factor_i[2] ? signed'(~mag + 12'd1) : signed'(mag);
    end

endmodule

// File: rtl/sobel_ci_ctrl.sv
// Sobel custom-instruction controller: 3-row pixel window, tap-serial Gx/Gy
// accumulation over one shared multiplier, returns |Gx|+|Gy|.
// Optional build macro: SOBEL_ZERO_SKIP_EN (12-step sequence skipping zero taps).
module sobel_ci_ctrl
    import sobel_pkg::*;
#(
    parameter logic [7:0] customId = 8'h19
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

`ifdef SOBEL_ZERO_SKIP_EN
    localparam logic [4:0] STEP_LAST = 5'(STEPS_SKIP - 1);
`else
    localparam logic [4:0] STEP_LAST = 5'(STEPS_FULL - 1);
`endif

    state_t                   state_q, state_d;
    logic [4:0]               step_q, step_d;
    logic [8:0][7:0]          win_q, win_d;     // pixel per tap, tap = 3*row + col
    logic signed [ACC_W-1:0]  gx_q, gx_d;
    logic signed [ACC_W-1:0]  gy_q, gy_d;

    logic                     accept;
    logic [1:0]               op;
    logic                     cur_is_gy;
    logic [3:0]               cur_tap;
    logic [2:0]               cur_coef;
    logic signed [ACC_W-1:0]  product;
    logic [ACC_W-1:0]         abs_gx, abs_gy, mag_sum;
    logic                     unused_bits;

    assign unused_bits = ^{valueA[31:24], valueB[31:2]};

    assign op     = valueB[1:0];
    assign accept = start && (ciN == customId) && (state_q == IDLE);

    // Map the step counter onto (kernel, tap)
`ifdef SOBEL_ZERO_SKIP_EN
    assign cur_is_gy = (step_q >= 5'd6);
    assign cur_tap   = SKIP_TAP[step_q[3:0]];
`else
    assign cur_is_gy = (step_q >= 5'd9);
    assign cur_tap   = cur_is_gy ? 4'(step_q - 5'd9) : step_q[3:0];
`endif

    assign cur_coef = cur_is_gy ? GY_COEF[cur_tap] : GX_COEF[cur_tap];

    sobel_tap_mult u_mult (
        .pixel_i   (win_q[cur_tap]),
        .factor_i  (cur_coef),
        .product_o (product)
    );

    // Gradient magnitude; max 2040 so the top bit of mag_sum is always zero
    assign abs_gx  = gx_q[ACC_W-1] ? (~gx_q + 12'd1) : gx_q;
    assign abs_gy  = gy_q[ACC_W-1] ? (~gy_q + 12'd1) : gy_q;
    assign mag_sum = abs_gx + abs_gy;

    // Next-state, datapath updates and CI outputs
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        win_d   = win_q;
        gx_d    = gx_q;
        gy_d    = gy_q;
        done    = 1'b0;
        result  = 32'd0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_COMPUTE) begin
                        gx_d    = '0;
                        gy_d    = '0;
                        step_d  = '0;
                        state_d = MAC;
                    end else begin
                        // LOAD and reserved ops complete immediately with result 0
                        done = 1'b1;
                        if (op == OP_LOAD) begin
                            // Scroll rows up, new row enters at the bottom
                            win_d = {valueA[23:0], win_q[8:3]};
                        end
                    end
                end
            end
            MAC: begin
                if (cur_is_gy) begin
                    gy_d = gy_q + product;
                end else begin
                    gx_d = gx_q + product;
                end
                if (step_q == STEP_LAST) begin
                    state_d = DONE;
                end else begin
                    step_d = step_q + 5'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                result  = {20'd0, mag_sum};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!nReset) begin
            state_q <= IDLE;
            step_q  <= '0;
            win_q   <= '0;
            gx_q    <= '0;
            gy_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            win_q   <= win_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
        end
    end

endmodule

// File: tb/tb_sobel_ci_ctrl.sv
// Directed bench for sobel_ci_ctrl with a result scoreboard and a
// reference window model. Honours SOBEL_ZERO_SKIP_EN for the latency.
module tb_sobel_ci_ctrl;

    localparam logic [7:0] CID = 8'h19;
`ifdef SOBEL_ZERO_SKIP_EN
    localparam int LAT = 13;
`else
    localparam int LAT = 19;
`endif

    logic        clock = 1'b0;
    logic        nReset;
    logic        start;
    logic [7:0]  ciN;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int mw[9];

    sobel_ci_ctrl #(.customId(CID)) dut (
        .clock  (clock),
        .nReset (nReset),
        .start  (start),
        .ciN    (ciN),
        .valueA (valueA),
        .valueB (valueB),
        .done   (done),
        .result (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic idle_bus();
        start  = 1'b0;
        ciN    = 8'h00;
        valueA = 32'd0;
        valueB = 32'd0;
    endtask

    // Independent reference: written-out Sobel sums over the model window
    function automatic int ref_mag();
        int gx, gy;
        gx = (mw[2] + 2 * mw[5] + mw[8]) - (mw[0] + 2 * mw[3] + mw[6]);
        gy = (mw[6] + 2 * mw[7] + mw[8]) - (mw[0] + 2 * mw[1] + mw[2]);
        return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 9; i++) mw[i] = 0;
    endtask

    task automatic do_load(input logic [23:0] row);
        start  = 1'b1;
        ciN    = CID;
        valueB = 32'hDEAD_BEE0;          // op bits 00, upper bits are noise
        valueA = {8'h5A, row};           // unused byte is noise
        #1;
        check("load_done", done, 1);
        check("load_result", result, 0);
        @(negedge clock);
        idle_bus();
        for (int i = 0; i < 6; i++) mw[i] = mw[i + 3];
        mw[6] = int'(row[7:0]);
        mw[7] = int'(row[15:8]);
        mw[8] = int'(row[23:16]);
        $display("LOAD     row=%06h", row);
    endtask

    // mode 0: plain; 1: inject LOADs while busy; 2: hold start through the DONE cycle
    task automatic do_compute(input int mode);
        int cyc;
        int expv;
        int seen;
        start  = 1'b1;
        ciN    = CID;
        valueB = 32'd1;
        valueA = 32'd0;
        #1;
        check("compute_accept_no_done", done, 0);
        exp_q.push_back(ref_mag());
        @(negedge clock);
        cyc = 1;
        forever begin
            if (mode == 1 && cyc >= 2 && cyc <= 4) begin
                start  = 1'b1;
                ciN    = CID;
                valueB = 32'd0;
                valueA = 32'h00AB_CDEF;
            end else begin
                idle_bus();
            end
            #1;
            if (done === 1'b1 || cyc >= LAT + 10) break;
            @(negedge clock);
            cyc++;
        end
        expv = exp_q.pop_front();
        check("compute_latency", cyc, LAT);
        check("compute_result", result, expv);
        $display("COMPUTE  result=%0d expected=%0d latency=%0d", result, expv, cyc);
        if (mode == 2) begin
            start  = 1'b1;
            ciN    = CID;
            valueB = 32'd1;
        end
        @(negedge clock);
        idle_bus();
        #1;
        check("done_pulse_width", done, 0);
        check("result_zero_after_done", result, 0);
        if (mode == 2) begin
            seen = 0;
            repeat (LAT + 6) begin
                @(negedge clock);
                #1;
                if (done !== 1'b0) seen = 1;
            end
            check("start_in_done_ignored", seen, 0);
        end
    endtask

    initial begin
        int seen;
        logic [23:0] rrow;

        // Reset and idle behaviour
        nReset = 1'b0;
        idle_bus();
        clear_model();
        repeat (2) @(negedge clock);
        #1;
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        @(negedge clock);
        nReset = 1'b1;

        // Foreign CI number: never answered
        for (int i = 0; i < 4; i++) begin
            start  = 1'b1;
            ciN    = 8'h18;
            valueB = i;
            valueA = 32'h00FF_FFFF;
            #1;
            check("foreign_ci_done", done, 0);
            check("foreign_ci_result", result, 0);
            @(negedge clock);
        end
        idle_bus();

        // Right column bright: gx = 1020
        repeat (3) do_load(24'hFF0000);
        do_compute(0);

        // Bottom row of 100s: gy = +400, twice without reloading
        do_load(24'h000000);
        do_load(24'h000000);
        do_load(24'h646464);
        do_compute(0);
        do_compute(0);

        // Top row saturated: gy = -1020
        do_load(24'hFFFFFF);
        do_load(24'h000000);
        do_load(24'h000000);
        do_compute(0);

        // Opposite corners cancel in both kernels
        do_load(24'h0000FF);
        do_load(24'h000000);
        do_load(24'hFF0000);
        do_compute(0);

        // Left column corners: gx = -510
        do_load(24'h0000FF);
        do_load(24'h000000);
        do_load(24'h0000FF);
        do_compute(0);

        // Busy: LOADs during MAC must be ignored, then result repeats
        do_compute(1);
        do_compute(0);

        // Foreign CI carrying a LOAD in IDLE leaves the window alone
        start  = 1'b1;
        ciN    = 8'h18;
        valueB = 32'd0;
        valueA = 32'h0012_3456;
        #1;
        check("foreign_load_done", done, 0);
        @(negedge clock);
        idle_bus();

        // Reserved ops complete at once with result 0
        for (int op = 2; op < 4; op++) begin
            start  = 1'b1;
            ciN    = CID;
            valueB = op;
            valueA = 32'h0077_7777;
            #1;
            check("reserved_done", done, 1);
            check("reserved_result", result, 0);
            $display("RESERVED op=%0d", op);
            @(negedge clock);
            idle_bus();
        end
        do_compute(0);

        // Start during DONE is dropped
        do_compute(2);

        // Random windows against the reference model
        for (int k = 0; k < 4; k++) begin
            repeat (3) begin
                rrow = 24'($urandom());
                do_load(rrow);
            end
            do_compute(0);
        end

        // Reset in the middle of MAC aborts without done
        do_load(24'h102030);
        start  = 1'b1;
        ciN    = CID;
        valueB = 32'd1;
        @(negedge clock);
        idle_bus();
        repeat (5) @(negedge clock);
        nReset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("reset_mid_done", done, 0);
        nReset = 1'b1;
        clear_model();
        seen = 0;
        repeat (LAT + 10) begin
            @(negedge clock);
            #1;
            if (done !== 1'b0) seen = 1;
        end
        check("reset_abort_no_done", seen, 0);
        $display("RESET    mid-compute abort");
        do_compute(0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
